// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network node datapath.
// Holds operand widths, default accumulator geometry, the per-beat side-band
// record carried down the pipeline, and the output clamp used at writeback.
package nn_pkg;

  localparam int unsigned WEIGHT_W      = 8;
  localparam int unsigned ACT_W         = 8;
  // Signed weight times zero-extended activation needs one extra bit.
  localparam int unsigned PROD_W        = WEIGHT_W + ACT_W + 1;
  localparam int unsigned BIAS_W        = 16;
  localparam int unsigned OUT_W         = 8;
  localparam int unsigned DEF_ACC_WIDTH = 24;
  localparam int unsigned DEF_FRAC_BITS = 4;

  // Side-band fields that travel with each term through stages P and A.
  typedef struct packed {
    logic              last;
    logic              layer_done;
    logic              last_layer;
    logic              bank;
    logic [BIAS_W-1:0] bias;
  } beat_meta_t;

  // Clamp a wide signed value to an 8-bit activation: [0,255] for hidden
  // layers, [-128,127] two's complement for the output layer.
  function automatic logic [OUT_W-1:0] clamp_act(input logic signed [63:0] val,
                                                 input logic              signed_mode);
    logic [OUT_W-1:0] res;
    if (signed_mode) begin
      if (val > 64'sd127) begin
        res = 8'h7f;
      end else if (val < -64'sd128) begin
        res = 8'h80;
      end else begin
        res = val[OUT_W-1:0];
      end
    end else begin
      if (val > 64'sd255) begin
        res = 8'hff;
      end else if (val < 64'sd0) begin
        res = 8'h00;
      end else begin
        res = val[OUT_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/nn_node_accumulator_if.sv
// Term-stream input and activation-memory write port of the node accumulator.
//   master: sequencer side, drives in_valid/weight/activation/bias and strobes.
//   slave : accumulator side, drives act_wr_* plus layer_end/busy/sat_flag.
interface nn_node_accumulator_if
  import nn_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
);

  logic                  in_valid;
  logic [WEIGHT_W-1:0]   weight;
  logic [ACT_W-1:0]      activation;
  logic [BIAS_W-1:0]     bias;
  logic                  node_done;
  logic                  layer_done;
  logic                  last_layer;
  logic                  mem_select;

  logic                  act_wr_en;
  logic                  act_wr_bank;
  logic [ADDR_WIDTH-1:0] act_wr_addr;
  logic [OUT_W-1:0]      act_wr_data;
  logic                  layer_end;
  logic                  busy;
  logic                  sat_flag;

  modport master (
    output in_valid, weight, activation, bias, node_done, layer_done, last_layer, mem_select,
    input  act_wr_en, act_wr_bank, act_wr_addr, act_wr_data, layer_end, busy, sat_flag
  );

  modport slave (
    input  in_valid, weight, activation, bias, node_done, layer_done, last_layer, mem_select,
    output act_wr_en, act_wr_bank, act_wr_addr, act_wr_data, layer_end, busy, sat_flag
  );

endinterface

// File: rtl/nn_postproc.sv
// Writeback post-processing (combinational): adds the bias to the final
// accumulator value, arithmetic-shifts by FRAC_BITS and clamps to 8 bits.
// Ports:
//   acc        in  final signed dot product
//   bias       in  signed node bias
//   last_layer in  1 selects signed [-128,127] output, 0 selects ReLU [0,255]
//   data       out resulting activation byte
module nn_postproc
  import nn_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int unsigned FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic signed [BIAS_W-1:0]    bias,
  input  logic                        last_layer,
  output logic [OUT_W-1:0]            data
);

  // One guard bit so the bias add can never wrap.
  localparam int unsigned SUM_W = ((ACC_WIDTH > BIAS_W) ? ACC_WIDTH : BIAS_W) + 1;

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] shifted;

  always_comb begin
    sum     = SUM_W'(acc) + SUM_W'(bias);
    shifted = sum >>> FRAC_BITS;
    data    = clamp_act(64'(shifted), last_layer);
  end

endmodule

// File: rtl/nn_node_accumulator.sv
// Multiply-accumulate stage for one network node at a time.
// Three-stage pipeline: P (product), A (saturating accumulate), W (bias,
// shift, clamp and activation-memory write into the bank not being read).
// Ports:
//   clk      in  rising-edge clock
//   reset_n  in  asynchronous active-low reset
//   bus      slave modport: term stream in, act_wr_*/layer_end/busy/sat_flag out
module nn_node_accumulator
  import nn_pkg::*;
#(
  parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input logic                  clk,
  input logic                  reset_n,
  nn_node_accumulator_if.slave bus
);

  // Headroom bit above the larger of accumulator and product widths.
  localparam int unsigned SUM_W = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 1;

  // Stage P
  logic                     first_q;
  logic                     p_valid_q;
  logic                     p_first_q;
  logic signed [PROD_W-1:0] p_prod_q;
  beat_meta_t               p_meta_q;
  logic signed [PROD_W-1:0] w_ext;
  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] prod_d;
  beat_meta_t               p_meta_d;

  // Stage A
  logic                        a_valid_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  beat_meta_t                  a_meta_q;
  logic signed [ACC_WIDTH-1:0] acc_d;
  logic                        acc_ovf;
  logic signed [SUM_W-1:0]     acc_wide;
  logic signed [SUM_W-1:0]     prod_wide;
  logic signed [SUM_W-1:0]     sum_wide;
  logic [SUM_W-ACC_WIDTH:0]    sum_hi;
  logic                        sat_q;

  // Stage W
  logic                  w_valid_q;
  logic                  wr_en_q;
  logic                  wr_bank_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [OUT_W-1:0]      wr_data_q;
  logic                  layer_end_q;
  logic [ADDR_WIDTH-1:0] node_cnt_q;
  logic [OUT_W-1:0]      post_data;

  // ---------------------------------------------------------------- stage P
  always_comb begin
    w_ext  = {{(PROD_W - WEIGHT_W){bus.weight[WEIGHT_W-1]}}, bus.weight};
    a_ext  = {{(PROD_W - ACT_W){1'b0}}, bus.activation};
    prod_d = w_ext * a_ext;

    p_meta_d.last       = bus.node_done;
    // layer_done is only meaningful on a node's last term.
    p_meta_d.layer_done = bus.node_done & bus.layer_done;
    p_meta_d.last_layer = bus.last_layer;
    p_meta_d.bank       = ~bus.mem_select;
    p_meta_d.bias       = bus.bias;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_q   <= 1'b1;
      p_valid_q <= 1'b0;
      p_first_q <= 1'b0;
      p_prod_q  <= '0;
      p_meta_q  <= '0;
    end else begin
      p_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        // The beat following a node's last term starts the next node.
        first_q   <= bus.node_done;
        p_first_q <= first_q;
        p_prod_q  <= prod_d;
        p_meta_q  <= p_meta_d;
      end
    end
  end

  // ---------------------------------------------------------------- stage A
  always_comb begin
    acc_wide  = SUM_W'(acc_q);
    prod_wide = SUM_W'(p_prod_q);
    sum_wide  = acc_wide + prod_wide;
    // All bits from the top down to the accumulator sign must agree to fit.
    sum_hi    = sum_wide[SUM_W-1:ACC_WIDTH-1];
    acc_ovf   = 1'b0;
    if (p_first_q) begin
      acc_d = prod_wide[ACC_WIDTH-1:0];
    end else if (!((&sum_hi) || !(|sum_hi))) begin
      acc_ovf = 1'b1;
      acc_d   = sum_wide[SUM_W-1] ? {1'b1, {(ACC_WIDTH - 1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH - 1){1'b1}}};
    end else begin
      acc_d = sum_wide[ACC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_valid_q <= 1'b0;
      acc_q     <= '0;
      a_meta_q  <= '0;
      sat_q     <= 1'b0;
    end else begin
      a_valid_q <= p_valid_q;
      if (p_valid_q) begin
        acc_q    <= acc_d;
        a_meta_q <= p_meta_q;
        sat_q    <= sat_q | acc_ovf;
      end
    end
  end

  // ---------------------------------------------------------------- stage W
  nn_postproc #(
    .ACC_WIDTH (ACC_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_postproc (
    .acc        (acc_q),
    .bias       (a_meta_q.bias),
    .last_layer (a_meta_q.last_layer),
    .data       (post_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_valid_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      layer_end_q <= 1'b0;
      node_cnt_q  <= '0;
    end else begin
      w_valid_q   <= a_valid_q;
      wr_en_q     <= a_valid_q & a_meta_q.last;
      layer_end_q <= a_valid_q & a_meta_q.last & a_meta_q.layer_done;
      if (a_valid_q && a_meta_q.last) begin
        wr_data_q  <= post_data;
        wr_bank_q  <= a_meta_q.bank;
        wr_addr_q  <= node_cnt_q;
        node_cnt_q <= a_meta_q.layer_done ? '0 : node_cnt_q + ADDR_WIDTH'(1);
      end
    end
  end

  assign bus.act_wr_en   = wr_en_q;
  assign bus.act_wr_bank = wr_bank_q;
  assign bus.act_wr_addr = wr_addr_q;
  assign bus.act_wr_data = wr_data_q;
  assign bus.layer_end   = layer_end_q;
  assign bus.sat_flag    = sat_q;
  assign bus.busy        = p_valid_q | a_valid_q | w_valid_q;

endmodule

// File: tb/tb_nn_node_accumulator.sv
// Scoreboard bench for nn_node_accumulator. Two instances share one stimulus
// stream: dut0 (ACC_WIDTH=16, FRAC_BITS=0) and dut1 (ACC_WIDTH=24, FRAC_BITS=4).
module tb_nn_node_accumulator;

  typedef struct {
    logic [7:0] data;
    logic [7:0] addr;
    logic       bank;
    logic       le;
    logic       sat;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic [7:0]  weight = '0;
  logic [7:0]  activation = '0;
  logic [15:0] bias = '0;
  logic        node_done = 1'b0;
  logic        layer_done = 1'b0;
  logic        last_layer = 1'b0;
  logic        mem_select = 1'b0;

  nn_node_accumulator_if #(.ADDR_WIDTH(8)) bus0 ();
  nn_node_accumulator_if #(.ADDR_WIDTH(8)) bus1 ();

  assign bus0.in_valid   = in_valid;
  assign bus0.weight     = weight;
  assign bus0.activation = activation;
  assign bus0.bias       = bias;
  assign bus0.node_done  = node_done;
  assign bus0.layer_done = layer_done;
  assign bus0.last_layer = last_layer;
  assign bus0.mem_select = mem_select;
  assign bus1.in_valid   = in_valid;
  assign bus1.weight     = weight;
  assign bus1.activation = activation;
  assign bus1.bias       = bias;
  assign bus1.node_done  = node_done;
  assign bus1.layer_done = layer_done;
  assign bus1.last_layer = last_layer;
  assign bus1.mem_select = mem_select;

  nn_node_accumulator #(.ACC_WIDTH(16), .FRAC_BITS(0), .ADDR_WIDTH(8)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  nn_node_accumulator #(.ACC_WIDTH(24), .FRAC_BITS(4), .ADDR_WIDTH(8)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  exp_t   sb0[$];
  exp_t   sb1[$];
  longint macc [2];
  bit     msat [2];
  bit     m_first = 1'b1;
  int     m_cnt = 0;
  int     acc_w [2] = '{16, 24};
  int     frac  [2] = '{0, 4};

  // Monitor observations of dut0 used by directed checks
  logic [7:0] last_data0;
  logic [7:0] last_addr0;
  int         wr_cnt0 = 0;
  logic [7:0] addr_hist0[$];
  logic       le_hist0[$];
  logic       bank_hist0[$];
  exp_t       e0;
  exp_t       e1;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic longint clampl(input longint v, input longint lo, input longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Issue one term and update the reference model from the arithmetic rules.
  task automatic send(input int w, input int a, input int b, input bit nd, input bit ld,
                      input bit ll, input bit ms);
    exp_t   e;
    longint p;
    longint s;
    longint lim;
    @(posedge clk);
    #1;
    in_valid   = 1'b1;
    weight     = 8'(w);
    activation = 8'(a);
    bias       = 16'(b);
    node_done  = nd;
    layer_done = ld;
    last_layer = ll;
    mem_select = ms;
    p = longint'(w) * longint'(a);
    for (int k = 0; k < 2; k++) begin
      if (m_first) begin
        macc[k] = p;
      end else begin
        s   = macc[k] + p;
        lim = longint'(1) <<< (acc_w[k] - 1);
        if (s > lim - 1) begin
          s = lim - 1;
          msat[k] = 1'b1;
        end else if (s < -lim) begin
          s = -lim;
          msat[k] = 1'b1;
        end
        macc[k] = s;
      end
      if (nd) begin
        s      = (macc[k] + longint'(b)) >>> frac[k];
        e.data = ll ? 8'(clampl(s, -128, 127)) : 8'(clampl(s, 0, 255));
        e.addr = 8'(m_cnt);
        e.bank = ~ms;
        e.le   = ld;
        e.sat  = msat[k];
        e.cyc  = cyc + 3;
        if (k == 0) sb0.push_back(e);
        else sb1.push_back(e);
      end
    end
    if (nd) m_cnt = ld ? 0 : (m_cnt + 1) % 256;
    m_first = nd;
  endtask

  // Idle beats; node_done/layer_done toggle without in_valid and must be ignored.
  task automatic idle(input int n, input bit strobes);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      node_done  = strobes ? 1'b1 : 1'($urandom_range(0, 1));
      layer_done = strobes ? 1'b1 : 1'($urandom_range(0, 1));
      weight     = 8'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    idle(1, 1'b0);
    while ((sb0.size() != 0 || sb1.size() != 0 || bus0.busy || bus1.busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d pending, expected 0", sb0.size(), sb1.size());
    end
  endtask

  task automatic reset_model();
    m_first = 1'b1;
    m_cnt   = 0;
    msat[0] = 1'b0;
    msat[1] = 1'b0;
    sb0.delete();
    sb1.delete();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_en0", bus0.act_wr_en, 0);
    chk("rst_data0", bus0.act_wr_data, 0);
    chk("rst_addr0", bus0.act_wr_addr, 0);
    chk("rst_bank0", bus0.act_wr_bank, 0);
    chk("rst_le0", bus0.layer_end, 0);
    chk("rst_busy0", bus0.busy, 0);
    chk("rst_sat0", bus0.sat_flag, 0);
    chk("rst_en1", bus1.act_wr_en, 0);
    chk("rst_busy1", bus1.busy, 0);
    chk("rst_sat1", bus1.sat_flag, 0);
  endtask

  // Monitors: pop and compare on each write strobe.
  always @(negedge clk) begin
    if (reset_n && bus0.act_wr_en) begin
      if (sb0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d0_unexpected_write: got addr %0d, expected no write", bus0.act_wr_addr);
      end else begin
        e0 = sb0.pop_front();
        chk("d0_data", bus0.act_wr_data, e0.data);
        chk("d0_addr", bus0.act_wr_addr, e0.addr);
        chk("d0_bank", bus0.act_wr_bank, e0.bank);
        chk("d0_layer_end", bus0.layer_end, e0.le);
        chk("d0_sat", bus0.sat_flag, e0.sat);
        chk("d0_latency", cyc, e0.cyc);
      end
      last_data0 = bus0.act_wr_data;
      last_addr0 = bus0.act_wr_addr;
      wr_cnt0++;
      addr_hist0.push_back(bus0.act_wr_addr);
      le_hist0.push_back(bus0.layer_end);
      bank_hist0.push_back(bus0.act_wr_bank);
    end
  end

  always @(negedge clk) begin
    if (reset_n && bus1.act_wr_en) begin
      if (sb1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d1_unexpected_write: got addr %0d, expected no write", bus1.act_wr_addr);
      end else begin
        e1 = sb1.pop_front();
        chk("d1_data", bus1.act_wr_data, e1.data);
        chk("d1_addr", bus1.act_wr_addr, e1.addr);
        chk("d1_bank", bus1.act_wr_bank, e1.bank);
        chk("d1_layer_end", bus1.layer_end, e1.le);
        chk("d1_sat", bus1.sat_flag, e1.sat);
        chk("d1_latency", cyc, e1.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int base;
    reset_model();
    @(negedge clk);
    chk_reset_outputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // 3-term node: 2*10 - 1*4 + 3*5 = 31, with busy/latency timing
    send(2, 10, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(-1, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(3, 5, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    t0 = cyc;
    idle(1, 1'b0);
    while (cyc < t0 + 3) @(negedge clk);
    chk("t1_wr_en_at_t3", bus0.act_wr_en, 1);
    chk("t1_busy_at_write", bus0.busy, 1);
    @(negedge clk);
    chk("t1_wr_en_after", bus0.act_wr_en, 0);
    chk("t1_busy_after", bus0.busy, 0);
    chk("t1_data", last_data0, 31);
    chk("t1_addr", last_addr0, 0);
    drain();

    // ReLU then signed mode: -40 + 8 = -32
    send(-8, 5, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    chk("relu_data", last_data0, 0);
    send(-8, 5, 8, 1'b1, 1'b1, 1'b1, 1'b0);
    drain();
    chk("signed_data", last_data0, 8'he0);
    chk("signed_addr", last_addr0, 2);

    // Back-to-back layers of single-term nodes
    addr_hist0.delete();
    le_hist0.delete();
    bank_hist0.delete();
    send(1, 3, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    send(2, 3, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    send(3, 3, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    send(4, 3, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    send(5, 3, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    chk("b2b_count", addr_hist0.size(), 5);
    if (addr_hist0.size() == 5) begin
      chk("b2b_addr0", addr_hist0[0], 0);
      chk("b2b_addr2", addr_hist0[2], 2);
      chk("b2b_addr3", addr_hist0[3], 0);
      chk("b2b_le1", le_hist0[1], 0);
      chk("b2b_le2", le_hist0[2], 1);
      chk("b2b_bank0", bank_hist0[0], 0);
      chk("b2b_bank3", bank_hist0[3], 1);
    end

    // Saturation in the 16-bit accumulator
    send(127, 255, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(127, 255, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(127, 255, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(127, 255, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    chk("sat_flag0", bus0.sat_flag, 1);
    chk("sat_flag1", bus1.sat_flag, 0);
    chk("sat_data0", last_data0, 255);
    idle(10, 1'b0);
    chk("sat_sticky0", bus0.sat_flag, 1);

    // Reset between term 2 and term 3 of a node
    base = wr_cnt0;
    send(9, 9, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(9, 9, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    reset_model();
    @(negedge clk);
    chk_reset_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    idle(6, 1'b0);
    chk("rst_no_write", wr_cnt0 - base, 0);
    send(5, 20, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    chk("rst_after_data", last_data0, 100);
    chk("rst_after_addr", last_addr0, 0);

    // Stray strobes between the two terms of a node
    base = wr_cnt0;
    send(3, 7, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b1);
    send(2, 9, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    chk("stray_writes", wr_cnt0 - base, 1);
    chk("stray_data", last_data0, 39);
    chk("stray_addr", last_addr0, 1);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle($urandom_range(1, 3), 1'b0);
      end else begin
        send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)),
             int'($urandom_range(0, 8191)) - 4096, ($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      end
    end
    drain();
    chk("final_sb0_empty", sb0.size(), 0);
    chk("final_sb1_empty", sb1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
